// File: rtl/turfio_bus_master.sv
// TURFIO-side initiator for the byte-serial TURF register bus.
// Converts single 32-bit register read/write requests into nCS/WnR/DIO sequences.
module turfio_bus_master #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned GAP    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        nCS_o,
    output logic        WnR_o,
    output logic [7:0]  dio_o,
    output logic        dio_oe_o,
    input  logic [7:0]  dio_i
);

    localparam int unsigned   CW        = 8;
    localparam logic [CW-1:0] TURN_LAST = CW'(RD_LAT - 1);
    // The IDLE cycle that samples the next request counts as the last gap cycle.
    localparam logic [CW-1:0] GAP_LAST  = (GAP > 1) ? CW'(GAP - 2) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_DONE,
        S_GAP
    } state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_cnt, w_cnt;
    logic [CW-1:0] r_wait, w_wait;
    logic          r_wr, w_wr;
    logic [7:0]    r_addr, w_addr;
    logic [31:0]   r_wdata, w_wdata;
    logic [23:0]   r_rshift, w_rshift;

    logic          r_busy, w_busy;
    logic          r_ack, w_ack;
    logic [31:0]   r_rdata, w_rdata;
    logic          r_ncs, w_ncs;
    logic          r_wnr, w_wnr;
    logic [7:0]    r_dio, w_dio;
    logic          r_oe, w_oe;

    // State, latched request and registered bus outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wait   <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rshift <= '0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_ncs    <= 1'b1;
            r_wnr    <= 1'b0;
            r_dio    <= '0;
            r_oe     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_wait   <= w_wait;
            r_wr     <= w_wr;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rshift <= w_rshift;
            r_busy   <= w_busy;
            r_ack    <= w_ack;
            r_rdata  <= w_rdata;
            r_ncs    <= w_ncs;
            r_wnr    <= w_wnr;
            r_dio    <= w_dio;
            r_oe     <= w_oe;
        end
    end

    // Next state, then the bus outputs that the next state presents.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_wait   = r_wait;
        w_wr     = r_wr;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_rshift = r_rshift;
        w_rdata  = r_rdata;
        w_busy   = 1'b1;
        w_ack    = 1'b0;
        w_ncs    = 1'b1;
        w_wnr    = 1'b0;
        w_dio    = '0;
        w_oe     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_state = S_ADDR;
                    w_wr    = wr_i;
                    w_addr  = addr_i;
                    w_wdata = wdata_i;
                end
            end
            S_ADDR: begin
                w_wait  = '0;
                w_state = r_wr ? S_WDATA : S_TURN;
            end
            S_WDATA: begin
                w_cnt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state = S_DONE;
                end
            end
            S_TURN: begin
                if (r_wait == TURN_LAST) begin
                    w_state = S_RDATA;
                end else begin
                    w_wait = r_wait + CW'(1);
                end
            end
            S_RDATA: begin
                w_rshift = {dio_i, r_rshift[23:8]};
                w_cnt    = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state = S_DONE;
                    w_rdata = {dio_i, r_rshift};
                end
            end
            S_DONE: begin
                w_wait  = '0;
                w_state = (GAP > 1) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_wait == GAP_LAST) begin
                    w_state = S_IDLE;
                end else begin
                    w_wait = r_wait + CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_busy = (w_state != S_IDLE);
        case (w_state)
            S_ADDR: begin
                w_ncs = 1'b0;
                w_wnr = w_wr;
                w_oe  = 1'b1;
                w_dio = w_addr;
            end
            S_WDATA: begin
                w_ncs = 1'b0;
                w_wnr = 1'b1;
                w_oe  = 1'b1;
                case (w_cnt)
                    2'd0:    w_dio = w_wdata[7:0];
                    2'd1:    w_dio = w_wdata[15:8];
                    2'd2:    w_dio = w_wdata[23:16];
                    default: w_dio = w_wdata[31:24];
                endcase
            end
            S_TURN, S_RDATA: begin
                w_ncs = 1'b0;
            end
            S_DONE: begin
                w_ack = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o   = r_busy;
    assign ack_o    = r_ack;
    assign rdata_o  = r_rdata;
    assign nCS_o    = r_ncs;
    assign WnR_o    = r_wnr;
    assign dio_o    = r_dio;
    assign dio_oe_o = r_oe;

endmodule

// File: tb/tb_turfio_bus_master.sv
// Scoreboard bench for turfio_bus_master: default build plus an RD_LAT=1/GAP=3 build.
module tb_turfio_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req0, req1, wr;
    logic [7:0]  addr, dio_in;
    logic [31:0] wdata;

    logic        busy0, ack0, ncs0, wnr0, oe0;
    logic        busy1, ack1, ncs1, wnr1, oe1;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  dio0, dio1;

    turfio_bus_master #(.RD_LAT(2), .GAP(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy0), .ack_o(ack0), .rdata_o(rdata0), .nCS_o(ncs0), .WnR_o(wnr0),
        .dio_o(dio0), .dio_oe_o(oe0), .dio_i(dio_in)
    );

    turfio_bus_master #(.RD_LAT(1), .GAP(3)) u_dut6 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy1), .ack_o(ack1), .rdata_o(rdata1), .nCS_o(ncs1), .WnR_o(wnr1),
        .dio_o(dio1), .dio_oe_o(oe1), .dio_i(dio_in)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int          iss;
        int          lat;
        int          low;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Only one build is active at a time; sel picks which one is observed.
    logic        m_ncs, m_oe, m_wnr, m_ack;
    logic [7:0]  m_dio;
    logic [31:0] m_rdata;
    assign m_ncs   = sel ? ncs1   : ncs0;
    assign m_oe    = sel ? oe1    : oe0;
    assign m_wnr   = sel ? wnr1   : wnr0;
    assign m_ack   = sel ? ack1   : ack0;
    assign m_dio   = sel ? dio1   : dio0;
    assign m_rdata = sel ? rdata1 : rdata0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TURF-side responder: after a read address, releases turnaround then returns 4 bytes LSB first.
    logic [31:0] rsp_w;
    initial begin
        dio_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && !m_ncs && m_oe && !m_wnr) begin
                rsp_w  = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
                dio_in = 8'hA5;
                repeat (sel ? 2 : 3) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    dio_in = rsp_w[8*i +: 8];
                    @(negedge clk);
                end
                dio_in = 8'h00;
            end
        end
    end

    // Bus monitor: rebuilds each transfer from the pins and scores it at ack.
    bit         mon_in_tr = 1'b0, mon_first = 1'b0, mon_oe_bad = 1'b0, mon_wnr = 1'b0;
    int         mon_low = 0, mon_high = 0, mon_gap = 0, mon_nb = 0;
    logic [7:0] mon_b[5];
    exp_t       mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_in_tr = 1'b0;
                mon_high  = 0;
            end else begin
                if (!m_ncs) begin
                    if (!mon_in_tr) begin
                        mon_in_tr  = 1'b1;
                        mon_gap    = mon_high;
                        mon_low    = 0;
                        mon_nb     = 0;
                        mon_oe_bad = 1'b0;
                        mon_wnr    = m_wnr;
                        mon_first  = 1'b1;
                    end
                    mon_low++;
                    if (m_oe) begin
                        if (mon_nb < 5) mon_b[mon_nb] = m_dio;
                        mon_nb++;
                    end
                    if (!mon_first && m_oe && !m_wnr) mon_oe_bad = 1'b1;
                    mon_first = 1'b0;
                    mon_high  = 0;
                end else begin
                    mon_high++;
                end
                if (m_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("latency", 32'(cyc - mon_e.iss), 32'(mon_e.lat));
                        check("ncs_low_cycles", 32'(mon_low), 32'(mon_e.low));
                        check("wnr", 32'(mon_wnr), 32'(mon_e.wr));
                        check("addr_byte", 32'(mon_b[0]), 32'(mon_e.addr));
                        check("driven_bytes", 32'(mon_nb), mon_e.wr ? 32'd5 : 32'd1);
                        check("oe_rule", 32'(mon_oe_bad), 32'd0);
                        if (mon_e.wr)
                            check("wdata", {mon_b[4], mon_b[3], mon_b[2], mon_b[1]}, mon_e.data);
                        else
                            check("rdata", m_rdata, mon_e.data);
                        if (mon_e.gap >= 0)
                            check("gap_cycles", 32'(mon_gap), 32'(mon_e.gap));
                    end
                    mon_in_tr = 1'b0;
                end
            end
        end
    end

    function automatic logic busy_sel();
        return sel ? busy1 : busy0;
    endfunction

    task automatic set_req(input logic v);
        if (sel) req1 = v;
        else     req0 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise req, wait (bounded) for acceptance, log expectation, then scramble inputs.
    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] rsp, input int gap, input bit hold, input bit expect_it);
        int   t;
        int   lat;
        exp_t e;
        wr    = w;
        addr  = a;
        wdata = d;
        set_req(1'b1);
        t = 0;
        while (busy_sel() && t < 100) begin
            tick();
            t++;
        end
        if (busy_sel()) begin
            check("accept_timeout", 32'd1, 32'd0);
            set_req(1'b0);
            return;
        end
        lat = sel ? 1 : 2;
        if (!w) rsp_q.push_back(rsp);
        if (expect_it) begin
            e.wr   = w;
            e.addr = a;
            e.data = w ? d : rsp;
            e.iss  = cyc;
            e.lat  = w ? 6 : 6 + lat;
            e.low  = w ? 5 : 5 + lat;
            e.gap  = gap;
            exp_q.push_back(e);
        end
        tick();
        if (!hold) set_req(1'b0);
        wr    = ~w;
        addr  = ~a;
        wdata = ~d;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_sel() && t < 100) begin
            tick();
            t++;
        end
        if (busy_sel()) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        wr    = 1'b0;
        addr  = 8'h00;
        wdata = 32'h0;
        repeat (3) tick();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_ncs", 32'(ncs0), 32'd1);
        check("rst_wnr", 32'(wnr0), 32'd0);
        check("rst_dio", 32'(dio0), 32'h0);
        check("rst_oe", 32'(oe0), 32'd0);
        check("rst6_ncs", 32'(ncs1), 32'd1);
        check("rst6_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        tick();

        // Single write and single read.
        issue(1'b1, 8'h12, 32'hDEADBEEF, 32'h0, -1, 1'b0, 1'b1);
        wait_idle();
        issue(1'b0, 8'h05, 32'h0, 32'h12345678, -1, 1'b0, 1'b1);
        wait_idle();

        // req held high: back-to-back transfers separated by DONE + GAP nCS-high cycles.
        issue(1'b1, 8'h21, 32'h01020304, 32'h0, -1, 1'b1, 1'b1);
        issue(1'b0, 8'h22, 32'h0, 32'hCAFEF00D, 2, 1'b1, 1'b1);
        issue(1'b1, 8'h23, 32'hA5A55A5A, 32'h0, 2, 1'b0, 1'b1);
        wait_idle();

        // Request pulse during write byte 2 must be ignored.
        issue(1'b1, 8'h40, 32'h11223344, 32'h0, -1, 1'b0, 1'b1);
        repeat (3) tick();
        addr  = 8'h99;
        wr    = 1'b1;
        wdata = 32'h55555555;
        req0  = 1'b1;
        tick();
        req0 = 1'b0;
        wait_idle();
        repeat (3) tick();

        // Reset during read byte 1: no ack, everything back to reset values.
        issue(1'b0, 8'h07, 32'h0, 32'h89ABCDEF, -1, 1'b0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_ncs", 32'(ncs0), 32'd1);
        check("midrst_oe", 32'(oe0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_rdata", rdata0, 32'h0);
        check("midrst_ack", 32'(ack0), 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        issue(1'b0, 8'h08, 32'h0, 32'h0BADCAFE, -1, 1'b0, 1'b1);
        wait_idle();

        // RD_LAT=1, GAP=3 build.
        sel = 1'b1;
        tick();
        issue(1'b0, 8'h33, 32'h0, 32'h55AA33CC, -1, 1'b0, 1'b1);
        wait_idle();
        issue(1'b1, 8'h34, 32'h00000001, 32'h0, -1, 1'b1, 1'b1);
        issue(1'b1, 8'h35, 32'hFFFFFFFF, 32'h0, 4, 1'b0, 1'b1);
        wait_idle();

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
        check("pending_expected", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
